// File: rtl/mem_pkg.sv
// Shared types, RAM geometry and load-extension helpers for the data RAM byte sequencer.
package mem_pkg;

  localparam int unsigned RAM_ADDR_W  = 11;
  localparam int unsigned BANK_ADDR_W = 9;
  localparam int unsigned NUM_BANKS   = 3;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_RESP
  } seq_state_t;

  // Sign- or zero-extend a right-aligned load value to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] data, input mem_size_t size,
                                              input logic unsigned_flag);
    logic        fill;
    logic [31:0] res;
    fill = ~unsigned_flag;
    case (size)
      SZ_BYTE: res = {{24{data[7] & fill}}, data[7:0]};
      SZ_HALF: res = {{16{data[15] & fill}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  // Index of the final byte of an access of the given size.
  function automatic logic [1:0] last_index(input mem_size_t size);
    logic [1:0] res;
    case (size)
      SZ_BYTE: res = 2'd0;
      SZ_HALF: res = 2'd1;
      default: res = 2'd3;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ram_byte_sequencer.sv
// Splits one CPU load/store into little-endian byte accesses on the banked 1536x8 data RAM,
// reassembles and extends load data, and rejects misaligned or out-of-range requests.
module ram_byte_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = mem_pkg::RAM_ADDR_W,
  parameter int unsigned BANK_ADDR_W = mem_pkg::BANK_ADDR_W,
  parameter int unsigned NUM_BANKS   = mem_pkg::NUM_BANKS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic              ram_re_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [7:0]        ram_wdata_o
);

  localparam int unsigned BANK_W = ADDR_W - BANK_ADDR_W;

  seq_state_t        state_q;
  logic              busy_q, done_q, err_q;
  logic              ram_re_q, ram_we_q;
  logic [ADDR_W-1:0] ram_raddr_q, ram_waddr_q;
  logic [7:0]        ram_wdata_q;
  logic [31:0]       rdata_q;

  logic              we_q, unsigned_q;
  mem_size_t         size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        cnt_q;

  logic [BANK_W-1:0] req_bank_c;
  logic              req_reject_c;
  logic [1:0]        last_idx_c;
  logic [31:0]       load_raw_c;

  assign req_bank_c = req_addr_i[ADDR_W-1:BANK_ADDR_W];
  assign last_idx_c = last_index(size_q);

  // Rejection is decided from the live request so ERR can be registered at the accepting edge.
  always_comb begin
    req_reject_c = 1'b0;
    case (mem_size_t'(req_size_i))
      SZ_HALF:    req_reject_c = req_addr_i[0];
      SZ_WORD:    req_reject_c = |req_addr_i[1:0];
      SZ_ILLEGAL: req_reject_c = 1'b1;
      default:    req_reject_c = 1'b0;
    endcase
    if (32'(req_bank_c) >= NUM_BANKS) begin
      req_reject_c = 1'b1;
    end
  end

  // Bytes shift in from the top; the final value is right-aligned by access size.
  always_comb begin
    asm_d      = {ram_rdata_i, asm_q[31:8]};
    load_raw_c = asm_d;
    case (size_q)
      SZ_BYTE: load_raw_c = {24'h000000, asm_d[31:24]};
      SZ_HALF: load_raw_c = {16'h0000, asm_d[31:16]};
      default: load_raw_c = asm_d;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        // The DONE cycle accepts a new request exactly like IDLE.
        ST_IDLE, ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (req_i) begin
            we_q       <= req_we_i;
            unsigned_q <= req_unsigned_i;
            size_q     <= mem_size_t'(req_size_i);
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            if (req_reject_c) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              busy_q  <= 1'b1;
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          cnt_q <= '0;
          if (we_q) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= addr_q;
            ram_wdata_q <= wdata_q[7:0];
            wdata_q     <= {8'h00, wdata_q[31:8]};
            state_q     <= ST_WRITE;
          end else begin
            ram_re_q    <= 1'b1;
            ram_raddr_q <= addr_q;
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (cnt_q != 2'd0) begin
            asm_q <= asm_d;
          end
          if (cnt_q == last_idx_c) begin
            state_q <= ST_DRAIN;
          end else begin
            cnt_q       <= cnt_q + 2'd1;
            ram_raddr_q <= ram_raddr_q + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          ram_re_q <= 1'b0;
          rdata_q  <= load_extend(load_raw_c, size_q, unsigned_q);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_RESP;
        end
        ST_WRITE: begin
          if (cnt_q == last_idx_c) begin
            ram_we_q <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_RESP;
          end else begin
            cnt_q       <= cnt_q + 2'd1;
            ram_waddr_q <= ram_waddr_q + ADDR_W'(1);
            ram_wdata_q <= wdata_q[7:0];
            wdata_q     <= {8'h00, wdata_q[31:8]};
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          ram_re_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign ram_re_o    = ram_re_q;
  assign ram_raddr_o = ram_raddr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_waddr_o = ram_waddr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_ram_byte_sequencer.sv
// Bench for ram_byte_sequencer: directed and random loads/stores against a byte-array memory model.
module tb_ram_byte_sequencer;

  localparam int unsigned AW = 11;
  localparam int POKE_ADDR = 'h100;

  logic          clk = 1'b0;
  logic          reset, req, req_we, req_unsigned;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_size;
  logic [31:0]   req_wdata;
  logic          busy, done, err, ram_re, ram_we;
  logic [31:0]   rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [7:0]    ram_rdata, ram_wdata;

  logic [7:0] ram [0:2047];
  bit         ram_wr [0:2047];
  logic [7:0] sh [0:2047];
  bit         sh_wr [0:2047];
  logic [7:0] salt;
  logic [31:0] exp_rdata;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_byte_sequencer dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
    .ram_re_o(ram_re), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
    .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata)
  );

  function automatic logic [7:0] mem_init(input int a);
    return 8'((a * 73 + 29) ^ (a >> 4)) ^ salt;
  endfunction

  function automatic logic [7:0] ram_rd(input int a);
    return ram_wr[a] ? ram[a] : mem_init(a);
  endfunction

  function automatic logic [7:0] sh_rd(input int a);
    return sh_wr[a] ? sh[a] : mem_init(a);
  endfunction

  // Synchronous RAM: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_rd(int'(ram_raddr));
    if (ram_we) begin
      ram[ram_waddr]    <= ram_wdata;
      ram_wr[ram_waddr] <= 1'b1;
    end
  end

  // Reference model: request rules applied directly to a byte array.
  task automatic model_txn(input logic we, input int addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] wd, output int exp_lat, output logic exp_err);
    int n;
    int v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr / 512 >= 3);
    exp_lat = 1;
    if (exp_err) return;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        sh[addr + i]    = 8'(wd >> (8 * i));
        sh_wr[addr + i] = 1'b1;
      end
      exp_lat = n + 2;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += (int'(sh_rd(addr + i)) << (8 * i));
      if (!uns && n == 1 && v >= 128) v -= 256;
      if (!uns && n == 2 && v >= 32768) v -= 65536;
      exp_rdata = 32'(v);
      exp_lat = n + 3;
    end
  endtask

  // Drive one request and observe it up to its DONE cycle; returns in the DONE cycle.
  task automatic run_txn(input logic we, input int addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] wd, input bit hold, input bit poke,
                         output int lat, output bit err_seen, output int re_n, output int we_n,
                         output bit busy_ok, output bit seq_ok);
    int n;
    int k;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    req = 1'b1; req_we = we; req_addr = AW'(addr); req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    lat = 0; err_seen = 1'b0; re_n = 0; we_n = 0; busy_ok = 1'b1; seq_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (poke && c == 2) begin
        req = 1'b1; req_we = 1'b1; req_addr = AW'(POKE_ADDR); req_size = 2'd2;
        req_wdata = 32'hA5A5_A5A5;
      end
      if (poke && c == 3) req = 1'b0;
      k = c - 2;
      if (ram_re && ram_we) seq_ok = 1'b0;
      if (ram_re) begin
        re_n++;
        if (k < 0 || we) seq_ok = 1'b0;
        else if (ram_raddr !== AW'(addr + ((k < n - 1) ? k : n - 1))) seq_ok = 1'b0;
      end
      if (ram_we) begin
        we_n++;
        if (k < 0 || !we) seq_ok = 1'b0;
        else if (ram_waddr !== AW'(addr + k) || ram_wdata !== 8'(wd >> (8 * k))) seq_ok = 1'b0;
      end
      if (done) begin
        lat = c;
        err_seen = err;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rdata = 32'h0;
    total_cnt++;
    if ({busy, done, err, ram_re, ram_we} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, ram_re, ram_we});
    else pass_cnt++;
    total_cnt++;
    if ({ram_raddr, ram_waddr, ram_wdata, rdata} !== '0)
      $display("FAIL reset_data got raddr=%h waddr=%h wdata=%h rdata=%h want all 0",
               ram_raddr, ram_waddr, ram_wdata, rdata);
    else pass_cnt++;
  endtask

  task automatic test_word_roundtrip();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    model_txn(1'b1, 'h004, 2'd2, 1'b0, 32'hDEAD_BEEF, el, ee);
    run_txn(1'b1, 'h004, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 6 || es !== 1'b0) $display("FAIL sw_done got lat=%0d err=%b want lat=6 err=0", lat, es);
    else pass_cnt++;
    total_cnt++;
    if (we_n !== 4 || re_n !== 0 || !sok || !bok)
      $display("FAIL sw_seq got we=%0d re=%0d seq=%b busy=%b want 4 0 1 1", we_n, re_n, sok, bok);
    else pass_cnt++;
    total_cnt++;
    if ({ram_rd(7), ram_rd(6), ram_rd(5), ram_rd(4)} !== 32'hDEAD_BEEF)
      $display("FAIL sw_mem got %h want deadbeef", {ram_rd(7), ram_rd(6), ram_rd(5), ram_rd(4)});
    else pass_cnt++;
    model_txn(1'b0, 'h004, 2'd2, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h004, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 7 || rdata !== 32'hDEAD_BEEF)
      $display("FAIL lw_result got lat=%0d rdata=%h want lat=7 rdata=deadbeef", lat, rdata);
    else pass_cnt++;
    total_cnt++;
    if (re_n !== 5 || we_n !== 0 || !sok || !bok)
      $display("FAIL lw_seq got re=%0d we=%0d seq=%b busy=%b want 5 0 1 1", re_n, we_n, sok, bok);
    else pass_cnt++;
  endtask

  task automatic test_byte_ext();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    model_txn(1'b0, 'h007, 2'd0, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h007, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 4 || rdata !== 32'hFFFF_FFDE || re_n !== 2 || !sok)
      $display("FAIL lb_signed got lat=%0d rdata=%h re=%0d want lat=4 rdata=ffffffde re=2", lat, rdata, re_n);
    else pass_cnt++;
    model_txn(1'b0, 'h007, 2'd0, 1'b1, 32'h0, el, ee);
    run_txn(1'b0, 'h007, 2'd0, 1'b1, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 4 || rdata !== 32'h0000_00DE)
      $display("FAIL lb_unsigned got lat=%0d rdata=%h want lat=4 rdata=000000de", lat, rdata);
    else pass_cnt++;
  endtask

  task automatic test_reject();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    int addrs [4] = '{'h201, 'h600, 'h000, 'h006};
    logic [1:0] sizes [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    for (int i = 0; i < 4; i++) begin
      model_txn(1'b0, addrs[i], sizes[i], 1'b0, 32'h0, el, ee);
      run_txn(1'b0, addrs[i], sizes[i], 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
      total_cnt++;
      if (lat !== 1 || es !== 1'b1 || re_n !== 0 || we_n !== 0 || rdata !== exp_rdata || !bok)
        $display("FAIL reject_%0d got lat=%0d err=%b re=%0d rdata=%h want lat=1 err=1 re=0 rdata=%h",
                 i, lat, es, re_n, rdata, exp_rdata);
      else pass_cnt++;
    end
  endtask

  task automatic test_half_and_bank2();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    logic [31:0] wd;
    model_txn(1'b1, 'h3FE, 2'd1, 1'b0, 32'h0000_8001, el, ee);
    run_txn(1'b1, 'h3FE, 2'd1, 1'b0, 32'h0000_8001, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 4 || we_n !== 2 || !sok || {ram_rd('h3FF), ram_rd('h3FE)} !== 16'h8001)
      $display("FAIL sh_store got lat=%0d we=%0d seq=%b mem=%h want 4 2 1 8001",
               lat, we_n, sok, {ram_rd('h3FF), ram_rd('h3FE)});
    else pass_cnt++;
    model_txn(1'b0, 'h3FE, 2'd1, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h3FE, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 5 || rdata !== 32'hFFFF_8001 || re_n !== 3)
      $display("FAIL lh_signed got lat=%0d rdata=%h re=%0d want 5 ffff8001 3", lat, rdata, re_n);
    else pass_cnt++;
    wd = $urandom;
    model_txn(1'b1, 'h5FC, 2'd2, 1'b0, wd, el, ee);
    run_txn(1'b1, 'h5FC, 2'd2, 1'b0, wd, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    model_txn(1'b0, 'h5FC, 2'd2, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h5FC, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 7 || es !== 1'b0 || rdata !== wd)
      $display("FAIL bank2_word got lat=%0d err=%b rdata=%h want 7 0 %h", lat, es, rdata, wd);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    model_txn(1'b0, 'h004, 2'd2, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h004, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 7 || rdata !== 32'hDEAD_BEEF || we_n !== 0 || !sok)
      $display("FAIL busy_ignore got lat=%0d rdata=%h we=%0d want 7 deadbeef 0", lat, rdata, we_n);
    else pass_cnt++;
    total_cnt++;
    if ({ram_rd(POKE_ADDR + 1), ram_rd(POKE_ADDR)} !== {sh_rd(POKE_ADDR + 1), sh_rd(POKE_ADDR)})
      $display("FAIL busy_poke_mem got %h want %h", {ram_rd(POKE_ADDR + 1), ram_rd(POKE_ADDR)},
               {sh_rd(POKE_ADDR + 1), sh_rd(POKE_ADDR)});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, re_n, we_n, el;
    bit es, bok, sok;
    logic ee;
    logic [31:0] wd;
    wd = $urandom;
    model_txn(1'b1, 'h020, 2'd2, 1'b0, wd, el, ee);
    run_txn(1'b1, 'h020, 2'd2, 1'b0, wd, 1'b1, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 6 || we_n !== 4 || !bok || !sok)
      $display("FAIL b2b_first got lat=%0d we=%0d busy=%b seq=%b want 6 4 1 1", lat, we_n, bok, sok);
    else pass_cnt++;
    model_txn(1'b0, 'h020, 2'd2, 1'b0, 32'h0, el, ee);
    run_txn(1'b0, 'h020, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
    total_cnt++;
    if (lat !== 7 || rdata !== wd || !bok)
      $display("FAIL b2b_second got lat=%0d rdata=%h busy=%b want 7 %h 1", lat, rdata, bok, wd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit quiet;
    req = 1'b1; req_we = 1'b1; req_addr = AW'('h010); req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_abort got we=%b busy=%b done=%b want 0 0 0", ram_we, busy, done);
    else pass_cnt++;
    reset = 1'b0;
    exp_rdata = 32'h0;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy || ram_we || ram_re) quiet = 1'b0;
    end
    total_cnt++;
    if (!quiet) $display("FAIL rst_mid_quiet got activity after abort want none");
    else pass_cnt++;
    sh['h010] = 8'h44; sh_wr['h010] = 1'b1;
    sh['h011] = 8'h33; sh_wr['h011] = 1'b1;
    total_cnt++;
    if ({ram_rd('h013), ram_rd('h012), ram_rd('h011), ram_rd('h010)} !==
        {sh_rd('h013), sh_rd('h012), 16'h3344})
      $display("FAIL rst_mid_mem got %h want %h",
               {ram_rd('h013), ram_rd('h012), ram_rd('h011), ram_rd('h010)},
               {sh_rd('h013), sh_rd('h012), 16'h3344});
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, re_n, we_n, el, addr, n;
    bit es, bok, sok;
    logic ee, we, uns;
    logic [1:0] size;
    logic [31:0] wd;
    for (int i = 0; i < 40; i++) begin
      size = 2'($urandom_range(0, 3));
      we   = 1'($urandom);
      uns  = 1'($urandom);
      wd   = $urandom;
      addr = int'($urandom_range(0, 2047));
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(n - 1);
      model_txn(we, addr, size, uns, wd, el, ee);
      run_txn(we, addr, size, uns, wd, 1'b0, 1'b0, lat, es, re_n, we_n, bok, sok);
      total_cnt++;
      if (lat !== el || es !== ee)
        $display("FAIL rnd%0d_done got lat=%0d err=%b want lat=%0d err=%b", i, lat, es, el, ee);
      else pass_cnt++;
      total_cnt++;
      if (rdata !== exp_rdata)
        $display("FAIL rnd%0d_rdata got %h want %h", i, rdata, exp_rdata);
      else pass_cnt++;
      total_cnt++;
      if (re_n !== ((ee || we) ? 0 : n + 1) || we_n !== ((ee || !we) ? 0 : n) || !sok || !bok)
        $display("FAIL rnd%0d_seq got re=%0d we=%0d seq=%b busy=%b", i, re_n, we_n, sok, bok);
      else pass_cnt++;
      if (we && !ee) begin
        for (int b = 0; b < n; b++) begin
          total_cnt++;
          if (ram_rd(addr + b) !== sh_rd(addr + b))
            $display("FAIL rnd%0d_mem%0d got %h want %h", i, b, ram_rd(addr + b), sh_rd(addr + b));
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    salt = 8'($urandom);
    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0; exp_rdata = 32'h0;
    test_reset();
    test_word_roundtrip();
    test_byte_ext();
    test_reject();
    test_half_and_bank2();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
